// File: rtl/keypad_scanner_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned MAP_W    = NUM_COLS * NUM_ROWS;
  localparam int unsigned CAND_W   = 5;

  // Candidate encoding: bit 4 set means no single key in the frame.
  localparam logic [CAND_W-1:0] CAND_NONE = 5'b1_0000;

  // Legend per map bit (4*row+col), entry 0 in the low nibble.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } kp_state_e;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

  // Single set bit gives its index; zero or several bits give NONE.
  function automatic logic [CAND_W-1:0] frame_cand(input logic [MAP_W-1:0] map);
    logic [4:0] cnt;
    logic [3:0] pos;
    cnt = '0;
    pos = '0;
    for (int i = 0; i < MAP_W; i++) begin
      if (map[i]) begin
        cnt = cnt + 5'd1;
        pos = 4'(i);
      end
    end
    return (cnt == 5'd1) ? {1'b0, pos} : CAND_NONE;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-rate debounce and press/release FSM; produces key reports and history.
module keypad_frame_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_done_c,
  input  logic [CAND_W-1:0] cand_c,
  output logic [3:0]        key,
  output logic              key_valid,
  output logic              key_held,
  output logic [15:0]       digits
);

  localparam int unsigned RUN_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_SCANS);

  kp_state_e         state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [CAND_W-1:0] prev_q, prev_d;
  logic [3:0]        key_q, key_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic [15:0]       digits_q, digits_d;
  logic              stable_c;
  logic [3:0]        code_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RELEASED;
      run_q    <= '0;
      prev_q   <= CAND_NONE;
      key_q    <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      digits_q <= digits_d;
    end
  end

  // Run length counts the current frame, so the FSM looks at run_d.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    prev_d   = prev_q;
    key_d    = key_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    digits_d = digits_q;
    stable_c = 1'b0;
    code_c   = key_code(cand_c[3:0]);
    if (frame_done_c) begin
      prev_d = cand_c;
      if (cand_c != prev_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
      stable_c = (run_d == RUN_MAX);
      case (state_q)
        ST_RELEASED: begin
          if (stable_c && !cand_c[CAND_W-1]) begin
            key_d    = code_c;
            digits_d = {digits_q[11:0], code_c};
            valid_d  = 1'b1;
            held_d   = 1'b1;
            state_d  = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (stable_c && cand_c[CAND_W-1]) begin
            held_d  = 1'b0;
            state_d = ST_RELEASED;
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end
  end

  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign digits    = digits_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: row synchronizer, column rotation and frame assembly.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [3:0]        row_meta_q, row_sync_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [MAP_W-1:0]  map_q, map_d;
  logic [3:0]        col_q, col_d;
  logic              sample_c;
  logic              frame_done_c;
  logic [CAND_W-1:0] cand_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      div_q      <= '0;
      idx_q      <= '0;
      map_q      <= '0;
      col_q      <= 4'b1110;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      idx_q      <= idx_d;
      map_q      <= map_d;
      col_q      <= col_d;
    end
  end

  // Sample only at the end of the settle window, then step to the next column.
  always_comb begin
    sample_c = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d    = div_q + DIV_W'(1);
    idx_d    = idx_q;
    map_d    = map_q;
    if (sample_c) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
      for (int r = 0; r < NUM_ROWS; r++) begin
        map_d[{r[1:0], idx_q}] = ~row_sync_q[r];
      end
    end
    col_d        = ~(4'b0001 << idx_d);
    frame_done_c = sample_c && (idx_q == 2'(NUM_COLS - 1));
    cand_c       = frame_cand(map_d);
  end

  assign col = col_q;

  keypad_frame_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .frame_done_c(frame_done_c),
    .cand_c      (cand_c),
    .key         (key),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .digits      (digits)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level reference model plus directed and random keypad stimulus.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state
  int          m_n;
  bit          m_live = 1'b0;
  int          m_hist[$];
  bit          m_held;
  bit          m_valid;
  logic [3:0]  m_key;
  logic [15:0] m_digits;
  bit          frame_edge;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held),
    .digits   (digits)
  );

  // Keypad: a pressed switch pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(int idx);
    string legend;
    byte   ch;
    legend = "123A456B789C0FED";
    ch = legend[idx];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  // -1 stands for "no single key".
  function automatic int cand_of(logic [15:0] p);
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < 16; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int  c;
    bit  stable;
    frame_edge = 1'b0;
    if (!rst_n) begin
      m_n = 0; m_hist.delete(); m_held = 0; m_valid = 0;
      m_key = '0; m_digits = '0; m_live = 1'b1;
      return;
    end
    m_n++;
    m_valid = 0;
    if (m_n % FRAME == 0) begin
      frame_edge = 1'b1;
      c = cand_of(pressed);
      m_hist.push_back(c);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      stable = (m_hist.size() == DEB);
      for (int i = 1; i < m_hist.size(); i++) if (m_hist[i] != m_hist[0]) stable = 0;
      if (!m_held && stable && c >= 0) begin
        m_key = code_of(c);
        m_digits = {m_digits[11:0], code_of(c)};
        m_valid = 1; m_held = 1;
      end else if (m_held && stable && c < 0) begin
        m_held = 0;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] ecol;
    if (!m_live) return;
    ecol = ~(4'b0001 << ((m_n / SD) % 4));
    check("col", col, ecol);
    check("key", key, m_key);
    check("key_valid", key_valid, m_valid);
    check("key_held", key_held, m_held);
    check("digits", digits, m_digits);
    if (key_valid === 1'b1) pulses++;
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); compare(); end

  task automatic frames(int k);
    while (k > 0) begin
      @(posedge clk); #1;
      if (frame_edge) k--;
    end
  endtask

  task automatic press_release(int b, int hold, int rel);
    pressed = 16'(1) << b;
    frames(hold);
    pressed = '0;
    frames(rel);
  endtask

  task automatic pulse_reset(int cyc);
    rst_n = 1'b0;
    repeat (cyc) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int kind;
    logic [15:0] p;
    rst_n = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_digits", digits, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Column rotation every SD cycles
    repeat (4) @(posedge clk); @(negedge clk); check("rot_1", col, 4'b1101);
    repeat (4) @(posedge clk); @(negedge clk); check("rot_2", col, 4'b1011);
    repeat (4) @(posedge clk); @(negedge clk); check("rot_3", col, 4'b0111);
    frames(1);

    // Single press of 5
    base = pulses;
    pressed = 16'(1) << 5;
    frames(10);
    pressed = '0;
    @(negedge clk);
    check("single_held", key_held, 1'b1);
    frames(4);
    @(negedge clk);
    check("single_pulses", pulses - base, 1);
    check("single_key", key, 4'h5);
    check("single_digits", digits, 16'h0005);
    check("single_released", key_held, 1'b0);

    // History 1 A 0 F then 7
    base = pulses;
    press_release(0, 3, 3);
    press_release(3, 3, 3);
    press_release(12, 3, 3);
    press_release(13, 3, 3);
    @(negedge clk);
    check("hist_digits", digits, 16'h1A0F);
    pressed = 16'(1) << 8;
    frames(3);
    @(negedge clk);
    check("hist_digits7", digits, 16'hA0F7);
    check("hist_pulses", pulses - base, 5);
    check("hist_key", key, 4'h7);
    pressed = '0;
    frames(3);

    // Bounce on key 3
    base = pulses;
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << 2) : 16'h0000;
      frames(1);
    end
    @(negedge clk);
    check("bounce_none", pulses - base, 0);
    pressed = 16'(1) << 2;
    frames(3);
    @(negedge clk);
    check("bounce_pulse", pulses - base, 1);
    check("bounce_key", key, 4'h3);
    pressed = '0;
    frames(3);

    // Chord 2+6, then 2 alone
    base = pulses;
    pressed = (16'(1) << 1) | (16'(1) << 6);
    frames(6);
    @(negedge clk);
    check("chord_none", pulses - base, 0);
    pressed = 16'(1) << 1;
    frames(3);
    @(negedge clk);
    check("chord_pulse", pulses - base, 1);
    check("chord_key", key, 4'h2);
    pressed = '0;
    frames(3);

    // Reset while D is held
    pressed = 16'(1) << 15;
    frames(3);
    @(negedge clk);
    check("d_held", key_held, 1'b1);
    check("d_key", key, 4'hD);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_digits", digits, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    base = pulses;
    frames(3);
    @(negedge clk);
    check("d_again_pulse", pulses - base, 1);
    check("d_again_key", key, 4'hD);
    check("d_again_digits", digits, 16'h000D);
    pressed = '0;
    frames(3);

    // Random keypad activity with occasional resets
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 2) p = '0;
      else if (kind <= 7) p = 16'(1) << $urandom_range(0, 15);
      else p = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      if (kind == 9) pulse_reset(int'($urandom_range(1, 3)));
      pressed = p;
      frames(int'($urandom_range(1, 4)));
    end
    pressed = '0;
    frames(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD on the Nexys 4) and turns each debounced key press into a 4-bit hex code with a one-cycle valid strobe. It also keeps a 16-bit history of the last four keys, sized to feed one half of the display controller's data input. It is the input-side counterpart to the multiplexed display path: columns are driven and rows are sampled, the way the display drives anodes and segments. It runs on the 100 MHz board clock.

## Interface
- SCAN_DIV, 100000: clock cycles each column is driven low (1 ms at 100 MHz); must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical scan frames required to accept a press or a release; must be ≥ 1.
- clk  in  1  board clock; everything is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- row  in  4  keypad rows, active-low (pulled up off-chip), asynchronous to clk.
- col  out  4  keypad columns, one-cold; the driven column is low.
- key  out  4  hex code of the last accepted key.
- key_valid  out  1  single-cycle pulse when key is updated.
- key_held  out  1  high from acceptance of a press until acceptance of its release.
- digits  out  16  last four accepted keys; digits[3:0] is the newest.

## Operation
- row passes through a two-flop synchronizer before any use.
- **Scan counter:** a column index 0..3 and a divide counter 0..SCAN_DIV-1.
  - col = ~(4'b0001 << index).
  - Sampling happens only when the divide counter = SCAN_DIV-1 (settle time). At that point the synchronized row is sampled into the frame map, then the index advances and wraps 3→0.
- **Frame:** a 16-bit pressed map, bit = 4*row+col, where pressed = row bit low.
  - A frame completes when column 3 is sampled.
  - The frame candidate is a key only if exactly one bit is set.
  - If zero bits are set, or two or more are set (ghosting or chord), the candidate is NONE.
- **Key map** (rows r0..r3, columns c0..c3):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = 0 F E D
  - code = hex value of the legend.
- **Debounce:**
  - The run length is the number of consecutive frames whose candidate equals the previous frame's candidate, counting the current frame.
  - The run length resets to 1 on any change and saturates at DEBOUNCE_SCANS.
- **FSM:**
  - RELEASED: if run length = DEBOUNCE_SCANS and the candidate is a key, then:
    - key ← code
    - digits ← {digits[11:0], code}
    - key_valid pulses
    - key_held ← 1
    - go to PRESSED.
  - PRESSED: if run length = DEBOUNCE_SCANS and the candidate is NONE, then key_held ← 0 and go to RELEASED. A stable different single key while in PRESSED is ignored; no new report is made until a release is accepted.
- **Reset values:**
  - col = 4'b1110
  - key = 0, key_valid = 0, key_held = 0, digits = 16'h0000
  - counters = 0; run length = 0; previous candidate = NONE
  - FSM = RELEASED
- Reset asserted mid-scan or mid-press restarts from the reset state. A key still held through reset is reported fresh once it is stable for DEBOUNCE_SCANS frames.

## Timing
- Frame period: 4*SCAN_DIV cycles.
- Row input to synchronized value: 2 cycles. Samples must not be taken earlier than divide count SCAN_DIV-1.
- **Press latency:** key_valid asserts the cycle after the sampling edge of column 3 in the DEBOUNCE_SCANS-th stable frame. key, digits and key_held update on that same edge.
- **Release latency:** key_held falls the cycle after the column-3 sample of the DEBOUNCE_SCANS-th stable NONE frame.
- key_valid is never high for two consecutive cycles. The maximum report rate is one press per 2*DEBOUNCE_SCANS frames.
- A press arriving partway through a frame counts from the first frame in which all four columns see it.

## Structure
- Shared package/header holds:
  - the NONE encoding (5-bit candidate, bit 4 = none)
  - the 16-entry key-map constant
  - column count = 4.
- One natural sub-module, keypad_frame_debounce, takes the per-frame candidate plus a frame_done strobe. It holds the run-length counter and the RELEASED/PRESSED FSM, and outputs key, key_valid, key_held and digits.
- The top level holds the synchronizer, the scan counter and frame-map assembly.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_SCANS=2. The keypad model drives row low when the matching col is low.

- **Reset:** hold reset low 3 cycles → col=1110, key=0, key_valid=0, digits=0000. After release, col rotates 1110→1101→1011→0111 every 4 cycles.
- **Single press:** hold key 5 (r1,c1) 10 frames, then release → exactly one key_valid, key=5, digits=0005. key_held goes high, then low about 2 frames after release.
- **History:** press and release 1, A, 0, F in sequence → digits=1A0F. Then press 7 → digits=A0F7 with 5 pulses total.
- **Bounce:** toggle key 3 on alternating frames for 8 frames → no key_valid. Then hold steady → one pulse with key=3.
- **Chord/ghost:** press 2 and 6 together for 6 frames → no pulse. Release 6 while holding 2 → one pulse with key=2.
- **Reset mid-press:** hold key D and pulse reset low after acceptance → key_held=0 and digits=0. With D still held, one new pulse with key=D after 2 stable frames.
